regfile_pipe: RTL and testbench

- Parametrised successor to the single-cycle 3-port register file, for the pipelined core.
- Provides XLEN-wide registers (NREGS of them) with two synchronous read ports, one write port, an optional hardwired zero register, and a per-register busy scoreboard for hazard detection.
- Sits between decode (reads and reservations) and writeback (writes and busy clears).

---
 rtl/regfile_pipe_if.sv | 32 +++
 rtl/regfile_pipe.sv | 94 +++++++++
 tb/tb_regfile_pipe.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pipe_if.sv
// Decode/writeback-facing bus of regfile_pipe: two registered read ports, one
// write port, a destination-reservation port and the two hazard flags.
interface regfile_pipe_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            rd_en;
  logic [AW-1:0]   a1;
  logic [AW-1:0]   a2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            rd_valid;
  logic            we3;
  logic [AW-1:0]   a3;
  logic [XLEN-1:0] wd3;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;
  logic            busy1;
  logic            busy2;

  modport master (
    output rd_en, a1, a2, we3, a3, wd3, rsv_en, rsv_addr,
    input  rd1, rd2, rd_valid, busy1, busy2
  );

  modport slave (
    input  rd_en, a1, a2, we3, a3, wd3, rsv_en, rsv_addr,
    output rd1, rd2, rd_valid, busy1, busy2
  );
endinterface

// File: rtl/regfile_pipe.sv
// Pipelined register file: two 1-cycle read ports, one write port, busy scoreboard.
// Define REGFILE_BYPASS_EN for write-first reads and same-cycle busy clearing.
module regfile_pipe #(
  parameter int  XLEN     = 32,
  parameter int  NREGS    = 32,
  parameter int  ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input logic           clk,
  input logic           rst_n,
  regfile_pipe_if.slave bus
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [XLEN-1:0]  rd1_q;
  logic [XLEN-1:0]  rd1_d;
  logic [XLEN-1:0]  rd2_q;
  logic [XLEN-1:0]  rd2_d;
  logic             rd_valid_q;
  logic             rd_valid_d;
  logic [XLEN-1:0]  val1;
  logic [XLEN-1:0]  val2;
  logic             zero_en;

  assign zero_en = (ZERO_REG != 0);

  // Zero-register override is applied last so it also beats the bypass path.
  always_comb begin
    val1 = regs_q[bus.a1];
    val2 = regs_q[bus.a2];
`ifdef REGFILE_BYPASS_EN
    if (bus.we3 && (bus.a3 == bus.a1)) val1 = bus.wd3;
    if (bus.we3 && (bus.a3 == bus.a2)) val2 = bus.wd3;
`endif
    if (zero_en && (bus.a1 == '0)) val1 = '0;
    if (zero_en && (bus.a2 == '0)) val2 = '0;
  end

  always_comb begin
    regs_d = regs_q;
    if (bus.we3 && !(zero_en && (bus.a3 == '0))) regs_d[bus.a3] = bus.wd3;
  end

  always_comb begin
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    rd_valid_d = bus.rd_en;
    if (bus.rd_en) begin
      rd1_d = val1;
      rd2_d = val2;
    end
  end

  // A reservation on the same edge as the write wins: a new producer is in flight.
  always_comb begin
    busy_d = busy_q;
    if (bus.we3) busy_d[bus.a3] = 1'b0;
    if (bus.rsv_en) busy_d[bus.rsv_addr] = 1'b1;
    if (zero_en) busy_d[0] = 1'b0;
  end

  always_comb begin
    bus.busy1 = busy_q[bus.a1];
    bus.busy2 = busy_q[bus.a2];
`ifdef REGFILE_BYPASS_EN
    if (bus.we3 && (bus.a3 == bus.a1)) bus.busy1 = 1'b0;
    if (bus.we3 && (bus.a3 == bus.a2)) bus.busy2 = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd1      = rd1_q;
  assign bus.rd2      = rd2_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_pipe.sv
// Scoreboard bench for regfile_pipe: expected read data is queued when a read is
// issued and popped when the registered result appears one cycle later.
module tb_regfile_pipe;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t sb_nz[$];
  logic [XLEN-1:0] mdl [NREGS];

  regfile_pipe_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();
  regfile_pipe_if #(.XLEN(XLEN), .NREGS(NREGS)) bus_nz ();

  regfile_pipe #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  regfile_pipe #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .bus(bus_nz)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.rd_en = 1'b0;    bus.a1 = '0;  bus.a2 = '0;
    bus.we3 = 1'b0;      bus.a3 = '0;  bus.wd3 = '0;
    bus.rsv_en = 1'b0;   bus.rsv_addr = '0;
    bus_nz.rd_en = 1'b0; bus_nz.a1 = '0; bus_nz.a2 = '0;
    bus_nz.we3 = 1'b0;   bus_nz.a3 = '0; bus_nz.wd3 = '0;
    bus_nz.rsv_en = 1'b0; bus_nz.rsv_addr = '0;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    idle();
    bus.we3 = 1'b1; bus.a3 = a; bus.wd3 = d;
    @(negedge clk);
    idle();
  endtask

  function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a, input logic we,
                                                 input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] v;
    v = mdl[a];
`ifdef REGFILE_BYPASS_EN
    if (we && (wa == a)) v = wd;
`else
    if (we && (wa == a) && 1'b0) v = wd;
`endif
    if (a == '0) v = '0;
    return v;
  endfunction

  task automatic test_reset();
    exp_t e;
    sb.delete();
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd1 !== '0 || bus.rd2 !== '0 || bus.busy1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got valid=%b rd1=%h rd2=%h busy1=%b expected all zero",
               bus.rd_valid, bus.rd1, bus.rd2, bus.busy1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    write_reg(5, 32'hDEADBEEF);
    bus.rd_en = 1'b1; bus.a1 = 5; bus.a2 = 5;
    e.rd1 = 32'hDEADBEEF; e.rd2 = 32'hDEADBEEF; sb.push_back(e);
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL reset_preload: got rd_valid=%b queued=%0d expected rd_valid=1", bus.rd_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if (bus.rd1 !== e.rd1 || bus.rd2 !== e.rd2) begin
        errors++;
        $display("[TB] FAIL reset_preload: got %h/%h expected %h/%h", bus.rd1, bus.rd2, e.rd1, e.rd2);
      end
    end
    bus.rd_en = 1'b1; bus.a1 = 5; bus.a2 = 5;
    bus.we3 = 1'b1; bus.a3 = 6; bus.wd3 = 32'hCAFEF00D;
    bus.rsv_en = 1'b1; bus.rsv_addr = 6;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd1 !== '0) begin
      errors++;
      $display("[TB] FAIL reset_async: got valid=%b rd1=%h expected 0/00000000", bus.rd_valid, bus.rd1);
    end
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd1 !== '0 || bus.rd2 !== '0) begin
      errors++;
      $display("[TB] FAIL reset_hold: got valid=%b rd1=%h rd2=%h expected all zero", bus.rd_valid, bus.rd1, bus.rd2);
    end
    idle();
    rst_n = 1'b1;
    bus.rd_en = 1'b1; bus.a1 = 5; bus.a2 = 6;
    #1;
    checks++;
    if (bus.busy2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rsv_dropped: got busy2=%b expected 0", bus.busy2);
    end
    e.rd1 = '0; e.rd2 = '0; sb.push_back(e);
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL reset_cleared: got rd_valid=%b queued=%0d expected rd_valid=1", bus.rd_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if (bus.rd1 !== e.rd1 || bus.rd2 !== e.rd2) begin
        errors++;
        $display("[TB] FAIL reset_cleared: got %h/%h expected %h/%h", bus.rd1, bus.rd2, e.rd1, e.rd2);
      end
    end
    idle();
  endtask

  task automatic test_basic_latency();
    exp_t e;
    sb.delete();
    write_reg(1, 32'h12345678);
    write_reg(2, 32'h87654321);
    bus.rd_en = 1'b1; bus.a1 = 1; bus.a2 = 2;
    e.rd1 = 32'h12345678; e.rd2 = 32'h87654321; sb.push_back(e);
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL latency_valid: got rd_valid=%b queued=%0d expected rd_valid=1", bus.rd_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if (bus.rd1 !== e.rd1 || bus.rd2 !== e.rd2) begin
        errors++;
        $display("[TB] FAIL latency_data: got %h/%h expected %h/%h", bus.rd1, bus.rd2, e.rd1, e.rd2);
      end
    end
    idle();
    bus.a1 = 3; bus.a2 = 4;
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd1 !== 32'h12345678 || bus.rd2 !== 32'h87654321) begin
      errors++;
      $display("[TB] FAIL latency_hold: got valid=%b rd1=%h rd2=%h expected 0/12345678/87654321",
               bus.rd_valid, bus.rd1, bus.rd2);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    exp_t e;
    sb.delete();
    sb_nz.delete();
    idle();
    bus.we3 = 1'b1; bus.a3 = 0; bus.wd3 = 32'hFFFFFFFF; bus.rsv_en = 1'b1; bus.rsv_addr = 0;
    bus_nz.we3 = 1'b1; bus_nz.a3 = 0; bus_nz.wd3 = 32'hFFFFFFFF; bus_nz.rsv_en = 1'b1; bus_nz.rsv_addr = 0;
    @(negedge clk);
    idle();
    bus.rd_en = 1'b1; bus.a1 = 0; bus.a2 = 0;
    bus_nz.rd_en = 1'b1; bus_nz.a1 = 0; bus_nz.a2 = 0;
    #1;
    checks++;
    if (bus.busy1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_busy: got busy1=%b expected 0", bus.busy1);
    end
    checks++;
    if (bus_nz.busy1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nonzero_busy: got busy1=%b expected 1", bus_nz.busy1);
    end
    e.rd1 = '0; e.rd2 = '0; sb.push_back(e);
    e.rd1 = 32'hFFFFFFFF; e.rd2 = 32'hFFFFFFFF; sb_nz.push_back(e);
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL zero_read: got rd_valid=%b queued=%0d expected rd_valid=1", bus.rd_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if (bus.rd1 !== e.rd1 || bus.rd2 !== e.rd2) begin
        errors++;
        $display("[TB] FAIL zero_read: got %h/%h expected %h/%h", bus.rd1, bus.rd2, e.rd1, e.rd2);
      end
    end
    checks++;
    if (bus_nz.rd_valid !== 1'b1 || sb_nz.size() == 0) begin
      errors++;
      $display("[TB] FAIL nonzero_read: got rd_valid=%b queued=%0d expected rd_valid=1", bus_nz.rd_valid, sb_nz.size());
    end else begin
      e = sb_nz.pop_front();
      if (bus_nz.rd1 !== e.rd1 || bus_nz.rd2 !== e.rd2) begin
        errors++;
        $display("[TB] FAIL nonzero_read: got %h/%h expected %h/%h", bus_nz.rd1, bus_nz.rd2, e.rd1, e.rd2);
      end
    end
    idle();
    bus.we3 = 1'b1; bus.a3 = 0; bus.wd3 = 32'h12345678;
    bus.rd_en = 1'b1; bus.a1 = 0; bus.a2 = 0;
    e.rd1 = '0; e.rd2 = '0; sb.push_back(e);
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL zero_same_cycle: got rd_valid=%b queued=%0d expected rd_valid=1", bus.rd_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if (bus.rd1 !== e.rd1 || bus.rd2 !== e.rd2) begin
        errors++;
        $display("[TB] FAIL zero_same_cycle: got %h/%h expected %h/%h", bus.rd1, bus.rd2, e.rd1, e.rd2);
      end
    end
    idle();
  endtask

  task automatic test_bypass();
    exp_t e;
    sb.delete();
    write_reg(7, 32'h11111111);
    bus.we3 = 1'b1; bus.a3 = 7; bus.wd3 = 32'hA5A5A5A5;
    bus.rd_en = 1'b1; bus.a1 = 7; bus.a2 = 7;
`ifdef REGFILE_BYPASS_EN
    e.rd1 = 32'hA5A5A5A5; e.rd2 = 32'hA5A5A5A5;
`else
    e.rd1 = 32'h11111111; e.rd2 = 32'h11111111;
`endif
    sb.push_back(e);
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL bypass_same_cycle: got rd_valid=%b queued=%0d expected rd_valid=1", bus.rd_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if (bus.rd1 !== e.rd1 || bus.rd2 !== e.rd2) begin
        errors++;
        $display("[TB] FAIL bypass_same_cycle: got %h/%h expected %h/%h", bus.rd1, bus.rd2, e.rd1, e.rd2);
      end
    end
    idle();
    bus.rd_en = 1'b1; bus.a1 = 7; bus.a2 = 7;
    e.rd1 = 32'hA5A5A5A5; e.rd2 = 32'hA5A5A5A5; sb.push_back(e);
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL bypass_next_read: got rd_valid=%b queued=%0d expected rd_valid=1", bus.rd_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if (bus.rd1 !== e.rd1 || bus.rd2 !== e.rd2) begin
        errors++;
        $display("[TB] FAIL bypass_next_read: got %h/%h expected %h/%h", bus.rd1, bus.rd2, e.rd1, e.rd2);
      end
    end
    idle();
  endtask

  task automatic test_scoreboard();
    exp_t e;
    logic exp_busy_wr;
    sb.delete();
    idle();
    bus.rsv_en = 1'b1; bus.rsv_addr = 3;
    @(negedge clk);
    idle();
    bus.a1 = 3;
    #1;
    checks++;
    if (bus.busy1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sb_reserve: got busy1=%b expected 1", bus.busy1);
    end
    bus.we3 = 1'b1; bus.a3 = 3; bus.wd3 = 32'h33333333;
`ifdef REGFILE_BYPASS_EN
    exp_busy_wr = 1'b0;
`else
    exp_busy_wr = 1'b1;
`endif
    #1;
    checks++;
    if (bus.busy1 !== exp_busy_wr) begin
      errors++;
      $display("[TB] FAIL sb_write_cycle: got busy1=%b expected %b", bus.busy1, exp_busy_wr);
    end
    @(negedge clk);
    idle();
    bus.a1 = 3;
    #1;
    checks++;
    if (bus.busy1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sb_cleared: got busy1=%b expected 0", bus.busy1);
    end
    bus.we3 = 1'b1; bus.a3 = 3; bus.wd3 = 32'h44444444; bus.rsv_en = 1'b1; bus.rsv_addr = 3;
    @(negedge clk);
    idle();
    bus.a1 = 3;
    #1;
    checks++;
    if (bus.busy1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sb_rsv_wins: got busy1=%b expected 1", bus.busy1);
    end
    bus.a1 = 0;
    bus.we3 = 1'b1; bus.a3 = 3; bus.wd3 = 32'h55555555; bus.rsv_en = 1'b1; bus.rsv_addr = 4;
    @(negedge clk);
    idle();
    bus.a1 = 3; bus.a2 = 4;
    #1;
    checks++;
    if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sb_split: got busy1=%b busy2=%b expected 0/1", bus.busy1, bus.busy2);
    end
    bus.rsv_en = 1'b1; bus.rsv_addr = 4;
    @(negedge clk);
    idle();
    bus.we3 = 1'b1; bus.a3 = 4; bus.wd3 = 32'h66666666;
    @(negedge clk);
    idle();
    bus.a2 = 4;
    #1;
    checks++;
    if (bus.busy2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sb_no_count: got busy2=%b expected 0", bus.busy2);
    end
    bus.rd_en = 1'b1; bus.a1 = 3; bus.a2 = 4;
    e.rd1 = 32'h55555555; e.rd2 = 32'h66666666; sb.push_back(e);
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL sb_data: got rd_valid=%b queued=%0d expected rd_valid=1", bus.rd_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if (bus.rd1 !== e.rd1 || bus.rd2 !== e.rd2) begin
        errors++;
        $display("[TB] FAIL sb_data: got %h/%h expected %h/%h", bus.rd1, bus.rd2, e.rd1, e.rd2);
      end
    end
    idle();
  endtask

  task automatic test_dual_port();
    exp_t e;
    sb.delete();
    write_reg(9, 32'h0BADF00D);
    write_reg(31, 32'hFEEDFACE);
    bus.rd_en = 1'b1; bus.a1 = 9; bus.a2 = 9;
    e.rd1 = 32'h0BADF00D; e.rd2 = 32'h0BADF00D; sb.push_back(e);
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL dual_same_addr: got rd_valid=%b queued=%0d expected rd_valid=1", bus.rd_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if (bus.rd1 !== e.rd1 || bus.rd2 !== e.rd2) begin
        errors++;
        $display("[TB] FAIL dual_same_addr: got %h/%h expected %h/%h", bus.rd1, bus.rd2, e.rd1, e.rd2);
      end
    end
    bus.a1 = 31; bus.a2 = 0;
    e.rd1 = 32'hFEEDFACE; e.rd2 = '0; sb.push_back(e);
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL top_reg: got rd_valid=%b queued=%0d expected rd_valid=1", bus.rd_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if (bus.rd1 !== e.rd1 || bus.rd2 !== e.rd2) begin
        errors++;
        $display("[TB] FAIL top_reg: got %h/%h expected %h/%h", bus.rd1, bus.rd2, e.rd1, e.rd2);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [XLEN-1:0] wd;
    logic            we;
    logic [AW-1:0]   wa;
    logic            re;
    sb.delete();
    idle();
    mdl[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      wd = $urandom;
      mdl[r] = wd;
      write_reg(AW'(r), wd);
    end
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      wa = AW'($urandom_range(0, NREGS - 1));
      wd = $urandom;
      re = ($urandom_range(0, 3) != 0);
      bus.we3 = we; bus.a3 = wa; bus.wd3 = wd;
      bus.rd_en = re;
      bus.a1 = ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(0, NREGS - 1));
      bus.a2 = AW'($urandom_range(0, NREGS - 1));
      if (re) begin
        e.rd1 = model_read(bus.a1, we, wa, wd);
        e.rd2 = model_read(bus.a2, we, wa, wd);
        sb.push_back(e);
      end
      if (we && (wa != '0)) mdl[wa] = wd;
      @(negedge clk);
      checks++;
      if (re) begin
        if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b_valid[%0d]: got rd_valid=%b queued=%0d expected rd_valid=1", i, bus.rd_valid, sb.size());
        end else begin
          e = sb.pop_front();
          if (bus.rd1 !== e.rd1 || bus.rd2 !== e.rd2) begin
            errors++;
            $display("[TB] FAIL b2b_data[%0d]: got %h/%h expected %h/%h", i, bus.rd1, bus.rd2, e.rd1, e.rd2);
          end
        end
      end else if (bus.rd_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_idle[%0d]: got rd_valid=%b expected 0", i, bus.rd_valid);
      end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_latency();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_dual_port();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
